branch_controller: RTL and testbench
====================================

BRANCH_CONTROLLER -- requirements
Module: branch_controller

Interface
REQ-001 SHALL have ports clk_ctrl (in, 1, sole clock, rising edge) and rst_ctrl (in, 1, reset; synchronous, active-high).
REQ-002 SHALL have pm_addr_ctrl (out, 8, program-memory address = PC) and pm_data_ctrl (in, 8, synchronous-ROM byte, valid one cycle after address).
REQ-003 SHALL have zero_ctrl and positive_ctrl (in, 1 each, datapath mux-output flags).
REQ-004 SHALL drive datapath controls: muxsel_ctrl (out, 2), imm_ctrl (out, 8), accwr_ctrl (out, 1), rfaddr_ctrl (out, 3), rfwr_ctrl (out, 1), alusel_ctrl (out, 3), shiftsel_ctrl (out, 2), outen_ctrl (out, 1).
REQ-005 SHALL have halted_ctrl (out, 1, high while in HALT).

Function
REQ-006 SHALL implement states FETCH, DECODE, OPND, LOADOP, EXEC, HALT.
REQ-007 FETCH -> DECODE unconditionally; pm_addr_ctrl = PC.
REQ-008 DECODE SHALL latch IR <= pm_data_ctrl and PC <= PC+1; one-byte opcode -> EXEC, two-byte opcode -> OPND.
REQ-009 OPND -> LOADOP (wait for ROM); LOADOP SHALL latch operand <= pm_data_ctrl, PC <= PC+1, -> EXEC.
REQ-010 EXEC -> FETCH, except HALT opcode -> HALT; HALT is left only by reset.
REQ-011 Latency: one-byte instruction 3 cycles, two-byte 5 cycles.
REQ-012 Opcode map (IR): 0x0F HALT; other 0x0X NOP; 0x1r LDA; 0x2r STA; 0x3X LDI #; 0x4X IN; 0x5X OUT; 0x6X JMP a; 0x7c Jcc a; 1aaa_srrr ALU.
REQ-013 Two-byte opcodes: LDI, JMP, Jcc; all others one-byte.
REQ-014 rfaddr_ctrl = IR[2:0], alusel_ctrl = IR[6:4], shiftsel_ctrl = {0, IR[3]}, imm_ctrl = operand register, at all times.
REQ-015 Strobes accwr/rfwr/outen SHALL be asserted only in EXEC, exactly one cycle; muxsel_ctrl = 00 outside EXEC.
REQ-016 EXEC actions: LDA accwr, mux 01; STA rfwr; LDI accwr, mux 11; IN accwr, mux 10; OUT outen; ALU accwr, mux 00.
REQ-017 Flag register {Z,P} SHALL load {zero_ctrl, positive_ctrl} on every edge where accwr_ctrl = 1, else hold.
REQ-018 Jcc condition IR[1:0]: 00 Z, 01 !Z, 10 P, 11 !P; taken -> PC <= operand in EXEC; not taken -> PC unchanged (already advanced).
REQ-019 JMP SHALL load PC <= operand unconditionally in EXEC.
REQ-020 PC SHALL be 8-bit and wrap 0xFF -> 0x00 on increment, no error.

Reset
REQ-021 rst_ctrl high at an edge SHALL force state FETCH, PC 0x00, IR 0x00, operand 0x00, Z=1, P=1, overriding any in-flight action.
REQ-022 During and one cycle after reset, all strobes 0, muxsel_ctrl 00, halted_ctrl 0, pm_addr_ctrl 0x00.

Structure
REQ-023 Opcode constants, Jcc condition codes and state encodings SHALL reside in shared package ctrl_pkg.
REQ-024 Combinational opcode-to-control decode SHALL be sub-module ctrl_decode; FSM, PC, IR, operand and flags stay in branch_controller.

Verification
REQ-025 Program 0x30,0x05,0x23,0x0F -> cycle 5 accwr=1, muxsel=11, imm=0x05; cycle 8 rfwr=1, rfaddr=3; halted_ctrl=1 from cycle 11.
REQ-026 ALU byte 0x8A -> EXEC: accwr=1, muxsel=00, alusel=000, shiftsel=01, rfaddr=2.
REQ-027 LDI 0x00 (zero_ctrl=1) then 0x70,0x10 -> next pm_addr_ctrl 0x10; with zero_ctrl=0 -> next address 0x04.
REQ-028 JMP to 0xFF holding NOP -> fetch sequence 0xFF, then 0x00.
REQ-029 Assert rst_ctrl during STA EXEC -> rfwr_ctrl 0 following cycle, pm_addr_ctrl 0x00, Z=P=1.
REQ-030 Byte 0x50 -> outen_ctrl high exactly one cycle (cycle 3), accwr/rfwr 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ctrl_pkg
// Brief  : Shared constants for the branch controller: FSM state encoding,
//          opcode groups (upper IR nibble), Jcc condition codes, datapath
//          mux selects and an instruction-length helper.
// Rev    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_OPND   = 3'd2,
      ST_LOADOP = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Opcode groups, selected by IR[7:4] when IR[7] = 0
   localparam logic [3:0] C_OP_SYS = 4'h0;   // NOP, or HALT when IR = 0x0F
   localparam logic [3:0] C_OP_LDA = 4'h1;
   localparam logic [3:0] C_OP_STA = 4'h2;
   localparam logic [3:0] C_OP_LDI = 4'h3;
   localparam logic [3:0] C_OP_IN  = 4'h4;
   localparam logic [3:0] C_OP_OUT = 4'h5;
   localparam logic [3:0] C_OP_JMP = 4'h6;
   localparam logic [3:0] C_OP_JCC = 4'h7;

   localparam logic [7:0] C_OP_HALT_BYTE = 8'h0F;

   // Jcc condition codes in IR[1:0]
   localparam logic [1:0] C_CC_Z  = 2'b00;
   localparam logic [1:0] C_CC_NZ = 2'b01;
   localparam logic [1:0] C_CC_P  = 2'b10;
   localparam logic [1:0] C_CC_NP = 2'b11;

   // Accumulator input mux selects
   localparam logic [1:0] C_MUX_ALU = 2'b00;
   localparam logic [1:0] C_MUX_RF  = 2'b01;
   localparam logic [1:0] C_MUX_IN  = 2'b10;
   localparam logic [1:0] C_MUX_IMM = 2'b11;

   // Instructions that carry an operand byte after the opcode
   function automatic logic is_two_byte(input logic [7:0] op);
      return (op[7] == 1'b0) &&
             ((op[7:4] == C_OP_LDI) || (op[7:4] == C_OP_JMP) || (op[7:4] == C_OP_JCC));
   endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : ctrl_decode
// Brief  : Purely combinational opcode-to-control decode. Strobes and the
//          mux select are only active while exec_i is high; field outputs
//          follow the IR at all times.
// Ports  : ir_i        instruction register
//          exec_i      controller is in its execute cycle
//          z_i, p_i    stored zero / positive flags
//          muxsel_o    accumulator input select (00 outside execute)
//          accwr_o, rfwr_o, outen_o   one-cycle strobes
//          rfaddr_o, alusel_o, shiftsel_o   IR field decode
//          is_halt_o   IR holds the HALT opcode
//          jump_o      load PC from operand this cycle
// Rev    : 1.0  initial release
// ============================================================================
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [7:0] ir_i,
   input  logic       exec_i,
   input  logic       z_i,
   input  logic       p_i,
   output logic [1:0] muxsel_o,
   output logic       accwr_o,
   output logic       rfwr_o,
   output logic       outen_o,
   output logic [2:0] rfaddr_o,
   output logic [2:0] alusel_o,
   output logic [1:0] shiftsel_o,
   output logic       is_halt_o,
   output logic       jump_o
);

   logic w_cc_true;

   assign rfaddr_o   = ir_i[2:0];
   assign alusel_o   = ir_i[6:4];
   assign shiftsel_o = {1'b0, ir_i[3]};
   assign is_halt_o  = (ir_i == C_OP_HALT_BYTE);

   always_comb begin
      w_cc_true = 1'b0;
      case (ir_i[1:0])
         C_CC_Z:  w_cc_true = z_i;
         C_CC_NZ: w_cc_true = ~z_i;
         C_CC_P:  w_cc_true = p_i;
         C_CC_NP: w_cc_true = ~p_i;
         default: w_cc_true = 1'b0;
      endcase
   end

   always_comb begin
      muxsel_o = C_MUX_ALU;
      accwr_o  = 1'b0;
      rfwr_o   = 1'b0;
      outen_o  = 1'b0;
      jump_o   = 1'b0;
      if (exec_i) begin
         if (ir_i[7]) begin
            accwr_o  = 1'b1;
            muxsel_o = C_MUX_ALU;
         end else begin
            case (ir_i[7:4])
               C_OP_LDA: begin
                  accwr_o  = 1'b1;
                  muxsel_o = C_MUX_RF;
               end
               C_OP_STA: rfwr_o = 1'b1;
               C_OP_LDI: begin
                  accwr_o  = 1'b1;
                  muxsel_o = C_MUX_IMM;
               end
               C_OP_IN: begin
                  accwr_o  = 1'b1;
                  muxsel_o = C_MUX_IN;
               end
               C_OP_OUT: outen_o = 1'b1;
               C_OP_JMP: jump_o  = 1'b1;
               C_OP_JCC: jump_o  = w_cc_true;
               default:  ;   // NOP / HALT: no datapath action
            endcase
         end
      end
   end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/branch_controller.sv
`default_nettype none
// ============================================================================
// Module : branch_controller
// Brief  : Multi-cycle fetch/decode/execute controller for an 8-bit
//          accumulator datapath with a synchronous program ROM.
//          Owns the FSM, PC, IR, operand register and {Z,P} flags.
// Ports  : clk_ctrl, rst_ctrl          clock, synchronous active-high reset
//          pm_addr_ctrl / pm_data_ctrl program ROM address / data (1-cycle)
//          zero_ctrl, positive_ctrl     datapath flags, captured on accwr
//          muxsel_ctrl, imm_ctrl, accwr_ctrl, rfaddr_ctrl, rfwr_ctrl,
//          alusel_ctrl, shiftsel_ctrl, outen_ctrl   datapath controls
//          halted_ctrl                  processor has halted
// Rev    : 1.0  initial release
// ============================================================================
module branch_controller
   import ctrl_pkg::*;
(
   input  logic       clk_ctrl,
   input  logic       rst_ctrl,
   output logic [7:0] pm_addr_ctrl,
   input  logic [7:0] pm_data_ctrl,
   input  logic       zero_ctrl,
   input  logic       positive_ctrl,
   output logic [1:0] muxsel_ctrl,
   output logic [7:0] imm_ctrl,
   output logic       accwr_ctrl,
   output logic [2:0] rfaddr_ctrl,
   output logic       rfwr_ctrl,
   output logic [2:0] alusel_ctrl,
   output logic [1:0] shiftsel_ctrl,
   output logic       outen_ctrl,
   output logic       halted_ctrl
);

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] opnd_q, opnd_d;
   logic       z_q, p_q;

   logic       w_exec;
   logic       w_is_halt;
   logic       w_jump;

   assign w_exec = (state_q == ST_EXEC);

   ctrl_decode u_decode (
      .ir_i       (ir_q),
      .exec_i     (w_exec),
      .z_i        (z_q),
      .p_i        (p_q),
      .muxsel_o   (muxsel_ctrl),
      .accwr_o    (accwr_ctrl),
      .rfwr_o     (rfwr_ctrl),
      .outen_o    (outen_ctrl),
      .rfaddr_o   (rfaddr_ctrl),
      .alusel_o   (alusel_ctrl),
      .shiftsel_o (shiftsel_ctrl),
      .is_halt_o  (w_is_halt),
      .jump_o     (w_jump)
   );

   assign pm_addr_ctrl = pc_q;
   assign imm_ctrl     = opnd_q;
   // Halt is reported from the HALT instruction's own execute cycle onward.
   assign halted_ctrl  = (state_q == ST_HALT) || (w_exec && w_is_halt);

   always_ff @(posedge clk_ctrl) begin
      if (rst_ctrl) begin
         state_q <= ST_FETCH;
         pc_q    <= 8'h00;
         ir_q    <= 8'h00;
         opnd_q  <= 8'h00;
         z_q     <= 1'b1;
         p_q     <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         opnd_q  <= opnd_d;
         if (accwr_ctrl) begin
            z_q <= zero_ctrl;
            p_q <= positive_ctrl;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      opnd_d  = opnd_q;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            // ROM data for the fetched address is valid now
            ir_d    = pm_data_ctrl;
            pc_d    = pc_q + 8'd1;
            state_d = is_two_byte(pm_data_ctrl) ? ST_OPND : ST_EXEC;
         end
         ST_OPND: state_d = ST_LOADOP;   // ROM read of the operand in flight
         ST_LOADOP: begin
            opnd_d  = pm_data_ctrl;
            pc_d    = pc_q + 8'd1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (w_jump) begin
               pc_d = opnd_q;
            end
            state_d = w_is_halt ? ST_HALT : ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

endmodule : branch_controller
`default_nettype wire

// File: tb/tb_branch_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_controller
// Brief  : Directed self-checking bench for branch_controller with a
//          behavioural synchronous program ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_branch_controller;

   logic       clk;
   logic       rst;
   logic [7:0] pm_addr;
   logic [7:0] pm_data;
   logic       zero;
   logic       positive;
   logic [1:0] muxsel;
   logic [7:0] imm;
   logic       accwr;
   logic [2:0] rfaddr;
   logic       rfwr;
   logic [2:0] alusel;
   logic [1:0] shiftsel;
   logic       outen;
   logic       halted;

   logic [7:0] rom [0:255];
   int         n_tests;
   int         n_fail;
   int         cyc;

   branch_controller dut (
      .clk_ctrl      (clk),
      .rst_ctrl      (rst),
      .pm_addr_ctrl  (pm_addr),
      .pm_data_ctrl  (pm_data),
      .zero_ctrl     (zero),
      .positive_ctrl (positive),
      .muxsel_ctrl   (muxsel),
      .imm_ctrl      (imm),
      .accwr_ctrl    (accwr),
      .rfaddr_ctrl   (rfaddr),
      .rfwr_ctrl     (rfwr),
      .alusel_ctrl   (alusel),
      .shiftsel_ctrl (shiftsel),
      .outen_ctrl    (outen),
      .halted_ctrl   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data for an address appears one cycle later
   always @(posedge clk) pm_data <= rom[pm_addr];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   // Cycle 1 = the cycle following the last edge that sampled reset high.
   task automatic reset_seq();
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      cyc = 1;
   endtask

   // Move to 2 time units after the edge that starts cycle k
   task automatic at_cycle(input int k);
      if (k > cyc) begin
         repeat (k - cyc) @(posedge clk);
         #2;
         cyc = k;
      end
   endtask

   task automatic jcc_case(input logic [7:0] op, input logic z, input logic p,
                           input logic [7:0] exp_addr, input string tag);
      rom_clear();
      rom[0] = 8'h30; rom[1] = 8'h00; rom[2] = op; rom[3] = 8'h10;
      zero = z; positive = p;
      reset_seq();
      at_cycle(10);
      chk({tag, "_exec_pc"}, pm_addr, 8'h04);
      at_cycle(11);
      chk({tag, "_next_addr"}, pm_addr, exp_addr);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0;
      rst = 1'b1; zero = 1'b0; positive = 1'b0;
      rom_clear();
      rom[0] = 8'h30; rom[1] = 8'h05; rom[2] = 8'h23; rom[3] = 8'h0F;

      // Reset held: everything quiet
      repeat (2) @(posedge clk);
      #2;
      chk("rst_accwr",  {7'd0, accwr}, 8'h00);
      chk("rst_rfwr",   {7'd0, rfwr},  8'h00);
      chk("rst_outen",  {7'd0, outen}, 8'h00);
      chk("rst_muxsel", {6'd0, muxsel}, 8'h00);
      chk("rst_halted", {7'd0, halted}, 8'h00);
      chk("rst_addr",   pm_addr, 8'h00);
      chk("rst_imm",    imm, 8'h00);
      rst = 1'b0; cyc = 1;

      // LDI #5; STA r3; HALT
      at_cycle(2);
      chk("c2_accwr", {7'd0, accwr}, 8'h00);
      at_cycle(5);
      chk("ldi_accwr",  {7'd0, accwr}, 8'h01);
      chk("ldi_muxsel", {6'd0, muxsel}, 8'h03);
      chk("ldi_imm",    imm, 8'h05);
      at_cycle(6);
      chk("ldi_done_accwr", {7'd0, accwr}, 8'h00);
      chk("fetch2_addr", pm_addr, 8'h02);
      at_cycle(8);
      chk("sta_rfwr",   {7'd0, rfwr}, 8'h01);
      chk("sta_rfaddr", {5'd0, rfaddr}, 8'h03);
      chk("sta_accwr",  {7'd0, accwr}, 8'h00);
      at_cycle(10);
      chk("pre_halt", {7'd0, halted}, 8'h00);
      at_cycle(11);
      chk("halt_c11", {7'd0, halted}, 8'h01);
      at_cycle(14);
      chk("halt_c14", {7'd0, halted}, 8'h01);
      chk("halt_addr", pm_addr, 8'h04);
      chk("halt_rfwr", {7'd0, rfwr}, 8'h00);

      // ALU 0x8A
      rom_clear(); rom[0] = 8'h8A;
      reset_seq();
      at_cycle(3);
      chk("alu_accwr",    {7'd0, accwr}, 8'h01);
      chk("alu_muxsel",   {6'd0, muxsel}, 8'h00);
      chk("alu_alusel",   {5'd0, alusel}, 8'h00);
      chk("alu_shiftsel", {6'd0, shiftsel}, 8'h01);
      chk("alu_rfaddr",   {5'd0, rfaddr}, 8'h02);
      at_cycle(4);
      chk("alu_after", {7'd0, accwr}, 8'h00);
      chk("alu_next_addr", pm_addr, 8'h01);

      // OUT 0x50
      rom_clear(); rom[0] = 8'h50;
      reset_seq();
      at_cycle(2);
      chk("out_c2", {7'd0, outen}, 8'h00);
      at_cycle(3);
      chk("out_c3", {7'd0, outen}, 8'h01);
      chk("out_accwr", {7'd0, accwr}, 8'h00);
      chk("out_rfwr",  {7'd0, rfwr}, 8'h00);
      at_cycle(4);
      chk("out_c4", {7'd0, outen}, 8'h00);

      // LDA r5; IN
      rom_clear(); rom[0] = 8'h15; rom[1] = 8'h41;
      reset_seq();
      at_cycle(3);
      chk("lda_accwr",  {7'd0, accwr}, 8'h01);
      chk("lda_muxsel", {6'd0, muxsel}, 8'h01);
      chk("lda_rfaddr", {5'd0, rfaddr}, 8'h05);
      at_cycle(6);
      chk("in_accwr",  {7'd0, accwr}, 8'h01);
      chk("in_muxsel", {6'd0, muxsel}, 8'h02);
      chk("in_alusel", {5'd0, alusel}, 8'h04);

      // Conditional jumps after LDI sets the flags
      jcc_case(8'h70, 1'b1, 1'b0, 8'h10, "jz_taken");
      jcc_case(8'h70, 1'b0, 1'b1, 8'h04, "jz_not");
      jcc_case(8'h71, 1'b0, 1'b0, 8'h10, "jnz_taken");
      jcc_case(8'h72, 1'b0, 1'b1, 8'h10, "jp_taken");
      jcc_case(8'h73, 1'b0, 1'b1, 8'h04, "jnp_not");

      // JMP 0xFF onto a NOP; PC wraps to 0x00
      rom_clear(); rom[0] = 8'h60; rom[1] = 8'hFF;
      reset_seq();
      at_cycle(6);
      chk("jmp_addr_ff", pm_addr, 8'hFF);
      at_cycle(9);
      chk("wrap_addr_00", pm_addr, 8'h00);

      // Reset during STA execute; flags clear to 0 beforehand
      rom_clear(); rom[0] = 8'h30; rom[1] = 8'h05; rom[2] = 8'h23;
      zero = 1'b0; positive = 1'b0;
      reset_seq();
      at_cycle(8);
      chk("sta2_rfwr", {7'd0, rfwr}, 8'h01);
      rst = 1'b1;
      rom_clear(); rom[0] = 8'h70; rom[1] = 8'h20; rom[8'h20] = 8'h72; rom[8'h21] = 8'h40;
      at_cycle(9);
      chk("rstmid_rfwr",   {7'd0, rfwr}, 8'h00);
      chk("rstmid_addr",   pm_addr, 8'h00);
      chk("rstmid_muxsel", {6'd0, muxsel}, 8'h00);
      chk("rstmid_halted", {7'd0, halted}, 8'h00);
      rst = 1'b0; cyc = 1;
      // Z=1 after reset: JZ taken
      at_cycle(6);
      chk("rst_z_set", pm_addr, 8'h20);
      // P=1 after reset: JP taken
      at_cycle(11);
      chk("rst_p_set", pm_addr, 8'h40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_branch_controller
`default_nettype wire
